rf_host_port: RTL and testbench

Host-side access controller that is the initiator for the register file's external-load and read-port-1 interface. It accepts single read/write commands from a debug host (switch panel or UART bridge) over a valid/ready handshake, sequences the register-file address/enable signals, and returns read data over a response handshake. It sits beside the processor datapath. While `busy` is high, the top level stalls the processor and muxes this block's `RF_ad1` onto the register file.

---
 rtl/rf_host_port.sv | 128 ++++++++++++
 tb/tb_rf_host_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_host_port.sv
// rf_host_port: debug-host command sequencer for the register-file load / read-port-1 interface.
// Defining RF_HOST_FILL_EN enables the 8-cycle fill opcode (10); otherwise 10 acts as reserved.
module rf_host_port #(
    parameter int NREGS = 8,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [2:0]    cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [2:0]    rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic [2:0]    RF_wa,
    output logic [DW-1:0] RF_wd,
    output logic          RF_external_load,
    output logic [2:0]    RF_ad1,
    input  logic [DW-1:0] RF_d1
);
    typedef enum logic [2:0] {
        IDLE, WR, RD_ADDR, RD_WAIT, RSP
`ifdef RF_HOST_FILL_EN
        , FILL
`endif
    } state_t;

    if (NREGS < 1 || NREGS > 8) begin : g_nregs_check
        $error("rf_host_port: NREGS must be between 1 and 8");
    end

    state_t        state_q, state_d;
    logic [2:0]    addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [2:0]    ad1_q, ad1_d;
    logic [2:0]    rsp_addr_q, rsp_addr_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          accept;
`ifdef RF_HOST_FILL_EN
    localparam logic [2:0] LAST = 3'(NREGS - 1);
    logic [2:0]    cnt_q, cnt_d;
`endif

    assign accept   = cmd_valid && cmd_ready;
    assign RF_wd    = data_q;
    assign RF_ad1   = ad1_q;
    assign rsp_addr = rsp_addr_q;
    assign rsp_data = rsp_data_q;

    // State register and command/response holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            ad1_q      <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
`ifdef RF_HOST_FILL_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ad1_q      <= ad1_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
`ifdef RF_HOST_FILL_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Next state: the opcode is decoded straight into the first state of each sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
                case (cmd_op)
                    2'b00:   state_d = RD_ADDR;
                    2'b01:   state_d = WR;
`ifdef RF_HOST_FILL_EN
                    2'b10:   state_d = FILL;
`endif
                    default: state_d = IDLE;
                endcase
            end
            WR:      state_d = IDLE;
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = RSP;
            RSP:     state_d = rsp_ready ? IDLE : RSP;
`ifdef RF_HOST_FILL_EN
            FILL:    state_d = (cnt_q == LAST) ? IDLE : FILL;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the command, hold the read address, capture registered read data at end of RD_WAIT.
    always_comb begin
        addr_d     = accept ? cmd_addr : addr_q;
        data_d     = accept ? cmd_data : data_q;
        ad1_d      = (accept && cmd_op == 2'b00) ? cmd_addr : ad1_q;
        rsp_addr_d = (state_q == RD_WAIT) ? ad1_q : rsp_addr_q;
        rsp_data_d = (state_q == RD_WAIT) ? RF_d1 : rsp_data_q;
`ifdef RF_HOST_FILL_EN
        cnt_d      = (state_q == FILL) ? cnt_q + 3'd1 : 3'd0;
`endif
    end

    // Outputs decoded from state; cmd_ready is forced low while reset is asserted.
    always_comb begin
        cmd_ready        = (state_q == IDLE) && !reset;
        busy             = state_q != IDLE;
        rsp_valid        = state_q == RSP;
        RF_external_load = state_q == WR;
        RF_wa            = addr_q;
`ifdef RF_HOST_FILL_EN
        RF_external_load = (state_q == WR) || (state_q == FILL);
        RF_wa            = (state_q == FILL) ? cnt_q : addr_q;
`endif
    end
endmodule

// File: tb/tb_rf_host_port.sv
// tb_rf_host_port: randomized host commands against a register-file model and an expected-contents array.
module tb_rf_host_port;
    localparam int DW = 4;

    logic          clk = 0;
    logic          reset = 0;
    logic          cmd_valid = 0;
    logic          rsp_ready = 0;
    logic [1:0]    cmd_op = 0;
    logic [2:0]    cmd_addr = 0;
    logic [DW-1:0] cmd_data = 0;
    logic          cmd_ready, rsp_valid, busy, RF_external_load;
    logic [2:0]    rsp_addr, RF_wa, RF_ad1;
    logic [DW-1:0] rsp_data, RF_wd, RF_d1;
    logic [DW-1:0] rf [8];
    logic [DW-1:0] ref_mem [8];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    rf_host_port #(.NREGS(8), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .busy(busy), .RF_wa(RF_wa), .RF_wd(RF_wd), .RF_external_load(RF_external_load),
        .RF_ad1(RF_ad1), .RF_d1(RF_d1)
    );

    // Register file: synchronous write, registered read on port 1.
    always @(posedge clk) begin
        if (RF_external_load) rf[RF_wa] <= RF_wd;
        RF_d1 <= rf[RF_ad1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wa"}, 32'(RF_wa), 0);
        chk({tag, "_wd"}, 32'(RF_wd), 0);
        chk({tag, "_load"}, 32'(RF_external_load), 0);
        chk({tag, "_ad1"}, 32'(RF_ad1), 0);
    endtask

    // Called at a negedge; returns 1 ns after the accepting posedge.
    task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [DW-1:0] d, output int waited);
        waited = 0;
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 32'(waited < 50), 1);
        @(posedge clk);
        #1;
        cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = 3'($urandom); cmd_data = DW'($urandom);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [DW-1:0] d);
        int w;
        send(2'b01, a, d, w);
        @(negedge clk);
        chk("wr_load", 32'(RF_external_load), 1);
        chk("wr_wa", 32'(RF_wa), 32'(a));
        chk("wr_wd", 32'(RF_wd), 32'(d));
        chk("wr_busy", 32'(busy), 1);
        @(negedge clk);
        chk("wr_load_off", 32'(RF_external_load), 0);
        chk("wr_idle", 32'(cmd_ready), 1);
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [2:0] a, input int hold);
        int w;
        logic [DW-1:0] exp;
        exp = ref_mem[a];
        rsp_ready = 0;
        send(2'b00, a, DW'($urandom), w);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rd_early_valid", 32'(rsp_valid), 0);
            chk("rd_ad1", 32'(RF_ad1), 32'(a));
            chk("rd_no_load", 32'(RF_external_load), 0);
        end
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_addr", 32'(rsp_addr), 32'(a));
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(exp));
            chk("hold_addr", 32'(rsp_addr), 32'(a));
            chk("hold_cmd_ready", 32'(cmd_ready), 0);
            chk("hold_busy", 32'(busy), 1);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_done", 32'(rsp_valid), 0);
        chk("rsp_idle", 32'(cmd_ready), 1);
    endtask

    task automatic do_idle_op(input logic [1:0] op, input logic [2:0] a, input logic [DW-1:0] d);
        int w;
        send(op, a, d, w);
        chk("idle_op_wait", 32'(w), 0);
        @(negedge clk);
        chk("idle_op_load", 32'(RF_external_load), 0);
        chk("idle_op_busy", 32'(busy), 0);
        chk("idle_op_rsp", 32'(rsp_valid), 0);
        chk("idle_op_ready", 32'(cmd_ready), 1);
    endtask

    task automatic do_fill(input logic [DW-1:0] d);
`ifdef RF_HOST_FILL_EN
        int w;
        send(2'b10, 3'($urandom), d, w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fill_load", 32'(RF_external_load), 1);
            chk("fill_wa", 32'(RF_wa), 32'(i));
            chk("fill_wd", 32'(RF_wd), 32'(d));
            chk("fill_busy", 32'(busy), 1);
        end
        @(negedge clk);
        chk("fill_end_load", 32'(RF_external_load), 0);
        chk("fill_end_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 8; i++) ref_mem[i] = d;
`else
        do_idle_op(2'b10, 3'($urandom), d);
`endif
    endtask

    task automatic reset_mid_fill(input logic [DW-1:0] d);
        int w;
        send(2'b10, 3'($urandom), d, w);
`ifdef RF_HOST_FILL_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rfill_load", 32'(RF_external_load), 1);
            chk("rfill_wa", 32'(RF_wa), 32'(i));
        end
        for (int i = 0; i < 4; i++) ref_mem[i] = d;
`else
        @(negedge clk);
        chk("rfill_no_load", 32'(RF_external_load), 0);
`endif
        @(posedge clk);
        #1;
        reset = 1;
        #1;
        check_zero("rst_fill");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_fill_ready", 32'(cmd_ready), 1);
        chk("rst_fill_busy", 32'(busy), 0);
    endtask

    task automatic reset_mid_rsp(input logic [2:0] a);
        int w;
        rsp_ready = 0;
        send(2'b00, a, 0, w);
        repeat (3) @(negedge clk);
        chk("rrsp_valid", 32'(rsp_valid), 1);
        reset = 1;
        #1;
        check_zero("rst_rsp");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rrsp_discard", 32'(rsp_valid), 0);
        chk("rrsp_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [2:0] a;
        logic [DW-1:0] d;
        #1 reset = 1;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("post_reset_ready", 32'(cmd_ready), 1);
        chk("post_reset_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) do_write(3'(i), DW'($urandom));
        do_write(3'd5, 4'h9);
        do_read(3'd5, 0);
        do_write(3'd2, 4'hA);
        do_read(3'd2, 5);
        do_fill(4'hF);
        do_read(3'd0, 0);
        do_read(3'd3, 0);
        do_read(3'd7, 0);
        do_idle_op(2'b11, 3'd1, 4'h6);
        do_read(3'd1, 0);
        do_write(3'd4, 4'h8);
        reset_mid_fill(4'h3);
        do_read(3'd3, 0);
        do_read(3'd4, 0);
        reset_mid_rsp(3'd6);
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            a = 3'($urandom);
            d = DW'($urandom);
            case (op)
                0:       do_read(a, $urandom_range(0, 3));
                1:       do_write(a, d);
                2:       do_fill(d);
                default: do_idle_op(2'b11, a, d);
            endcase
        end
        for (int i = 0; i < 8; i++) do_read(3'(i), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
